// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg -- shared definitions for the LCD write-bus receiver.
//   Command codes of the ILI9341 subset, the receiver FSM state type,
//   the parameter decoding mode, the MADCTL MV bit position and the
//   pixel byte-pair assembly helper.
package lcd_bus_pkg;

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;
  localparam logic [7:0] CMD_MADCTL = 8'h36;

  localparam int unsigned MADCTL_MV = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PARAM,
    S_PIX0,
    S_PIX1
  } state_t;

  // How the parameter bytes of the current command are interpreted.
  typedef enum logic [1:0] {
    PM_GENERIC,
    PM_CASET,
    PM_PASET,
    PM_MADCTL
  } param_mode_t;

  // Joins the two bus bytes of one pixel into an RGB565 word.
  function automatic logic [15:0] pixel_word(input logic [7:0] first,
                                             input logic [7:0] second,
                                             input logic       low_first);
    return low_first ? {second, first} : {first, second};
  endfunction

endpackage

// File: rtl/lcd_bus_receiver_sync.sv
// lcd_bus_sync -- brings the asynchronous 8080 bus pins into i_clk.
//   Two-flop synchronisers on DATA, RS, WR, CS and RESET_INVERTED, with a
//   history flop on WR and CS for edge detection.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_lcd_*                 raw bus pins
//   o_strobe                one-cycle pulse per WR rising edge while selected
//   o_data, o_rs            byte and RS captured from the same stage as o_strobe
//   o_deselect              one-cycle pulse when CS falls
//   o_bus_reset             synchronised RESET_INVERTED level
module lcd_bus_sync (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_lcd_data,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_wr,
  input  logic       i_lcd_cs_inverted,
  input  logic       i_lcd_reset_inverted,
  output logic       o_strobe,
  output logic [7:0] o_data,
  output logic       o_rs,
  output logic       o_deselect,
  output logic       o_bus_reset
);

  logic [7:0] r_data_s1, r_data_s2;
  logic       r_rs_s1, r_rs_s2;
  logic       r_wr_s1, r_wr_s2, r_wr_hist;
  logic       r_cs_s1, r_cs_s2, r_cs_hist;
  logic       r_rst_s1, r_rst_s2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data_s1 <= '0;
      r_data_s2 <= '0;
      r_rs_s1   <= 1'b0;
      r_rs_s2   <= 1'b0;
      // WR idles high; resetting its stages high avoids a false edge
      // when reset is released with the strobe already high.
      r_wr_s1   <= 1'b1;
      r_wr_s2   <= 1'b1;
      r_wr_hist <= 1'b1;
      r_cs_s1   <= 1'b0;
      r_cs_s2   <= 1'b0;
      r_cs_hist <= 1'b0;
      r_rst_s1  <= 1'b0;
      r_rst_s2  <= 1'b0;
    end else begin
      r_data_s1 <= i_lcd_data;
      r_data_s2 <= r_data_s1;
      r_rs_s1   <= i_lcd_rs;
      r_rs_s2   <= r_rs_s1;
      r_wr_s1   <= i_lcd_wr;
      r_wr_s2   <= r_wr_s1;
      r_wr_hist <= r_wr_s2;
      r_cs_s1   <= i_lcd_cs_inverted;
      r_cs_s2   <= r_cs_s1;
      r_cs_hist <= r_cs_s2;
      r_rst_s1  <= i_lcd_reset_inverted;
      r_rst_s2  <= r_rst_s1;
    end
  end

  assign o_strobe    = r_wr_s2 & ~r_wr_hist & r_cs_s2;
  assign o_data      = r_data_s2;
  assign o_rs        = r_rs_s2;
  assign o_deselect  = r_cs_hist & ~r_cs_s2;
  assign o_bus_reset = r_rst_s2;

endmodule

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver -- responder for the 8-bit 8080-style LCD write bus.
//   Decodes CASET/PASET/RAMWR/RAMWRC (and MADCTL when enabled), reports
//   every command and parameter byte, and emits RGB565 pixels tagged with
//   their column/page inside the current window.
// Optional feature: define LCD_BUS_RECEIVER_MADCTL_EN to honour MADCTL MV
//   (page-first traversal); otherwise 0x36 is a generic command.
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_lcd_data/rs/wr/cs_inverted      asynchronous bus pins
//   i_lcd_reset_inverted              bus reset, same effect as i_reset
//   o_cmd_valid/o_cmd                 command pulse and last command byte
//   o_param_valid/o_param             parameter pulse and byte
//   o_pixel_valid/data/x/y            pixel pulse, RGB565 value, coordinates
//   o_frame_done                      with the last pixel of the window
module lcd_bus_receiver #(
  parameter int P_COLS           = 240,
  parameter int P_ROWS           = 320,
  parameter int P_LOW_BYTE_FIRST = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_lcd_data,
  input  logic        i_lcd_rs,
  input  logic        i_lcd_wr,
  input  logic        i_lcd_cs_inverted,
  input  logic        i_lcd_reset_inverted,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_param_valid,
  output logic [7:0]  o_param,
  output logic        o_pixel_valid,
  output logic [15:0] o_pixel_data,
  output logic [8:0]  o_pixel_x,
  output logic [8:0]  o_pixel_y,
  output logic        o_frame_done
);
  import lcd_bus_pkg::*;

  localparam logic [15:0] LP_COLS     = 16'(P_COLS);
  localparam logic [15:0] LP_ROWS     = 16'(P_ROWS);
  localparam logic [8:0]  LP_COL_LAST = 9'(P_COLS - 1);
  localparam logic [8:0]  LP_ROW_LAST = 9'(P_ROWS - 1);
  localparam logic        LP_LOW_FIRST = (P_LOW_BYTE_FIRST != 0);

  logic       w_strobe;
  logic [7:0] w_byte;
  logic       w_rs;
  logic       w_deselect;
  logic       w_bus_reset;
  logic       w_rst;

  lcd_bus_sync u_sync (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_lcd_data           (i_lcd_data),
    .i_lcd_rs             (i_lcd_rs),
    .i_lcd_wr             (i_lcd_wr),
    .i_lcd_cs_inverted    (i_lcd_cs_inverted),
    .i_lcd_reset_inverted (i_lcd_reset_inverted),
    .o_strobe             (w_strobe),
    .o_data               (w_byte),
    .o_rs                 (w_rs),
    .o_deselect           (w_deselect),
    .o_bus_reset          (w_bus_reset)
  );

  assign w_rst = i_reset | w_bus_reset;

  state_t      r_state, w_state_next;
  param_mode_t r_mode;
  logic [2:0]  r_idx;
  logic [7:0]  r_pbuf0, r_pbuf1, r_pbuf2;
  logic [8:0]  r_col_start, r_col_end, r_row_start, r_row_end;
  logic [8:0]  r_x, r_y;
  logic [7:0]  r_pix_first;
  logic        w_mv;

  logic        w_cmd_evt, w_param_evt, w_pix_lat, w_pix_done;
  logic [8:0]  w_x_adv, w_y_adv;
  logic        w_wrap;
  logic [15:0] w_start16, w_end16;
  logic        w_col_ok, w_row_ok;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_evt    = 1'b0;
    w_param_evt  = 1'b0;
    w_pix_lat    = 1'b0;
    w_pix_done   = 1'b0;
    if (w_deselect) begin
      w_state_next = S_IDLE;
    end else if (w_strobe) begin
      if (!w_rs) begin
        w_cmd_evt = 1'b1;
        if (w_byte == CMD_RAMWR || w_byte == CMD_RAMWRC) w_state_next = S_PIX0;
        else                                             w_state_next = S_PARAM;
      end else begin
        case (r_state)
          S_PARAM: w_param_evt = 1'b1;
          S_PIX0: begin
            w_pix_lat    = 1'b1;
            w_state_next = S_PIX1;
          end
          S_PIX1: begin
            w_pix_done   = 1'b1;
            w_state_next = S_PIX0;
          end
          default: ;
        endcase
      end
    end
  end

  // ----------------------------------------------------- pointer advance
`ifdef LCD_BUS_RECEIVER_MADCTL_EN
  logic r_mv;
  assign w_mv = r_mv;
`else
  assign w_mv = 1'b0;
`endif

  // The fast axis wraps to its start and steps the slow axis; the slow
  // axis wrapping marks the end of the window.
  always_comb begin
    w_x_adv = r_x;
    w_y_adv = r_y;
    w_wrap  = 1'b0;
    if (!w_mv) begin
      if (r_x == r_col_end) begin
        w_x_adv = r_col_start;
        if (r_y == r_row_end) begin
          w_y_adv = r_row_start;
          w_wrap  = 1'b1;
        end else begin
          w_y_adv = r_y + 9'd1;
        end
      end else begin
        w_x_adv = r_x + 9'd1;
      end
    end else begin
      if (r_y == r_row_end) begin
        w_y_adv = r_row_start;
        if (r_x == r_col_end) begin
          w_x_adv = r_col_start;
          w_wrap  = 1'b1;
        end else begin
          w_x_adv = r_x + 9'd1;
        end
      end else begin
        w_y_adv = r_y + 9'd1;
      end
    end
  end

  // Window bounds are always sent high byte first; the 4th byte is live.
  assign w_start16 = {r_pbuf0, r_pbuf1};
  assign w_end16   = {r_pbuf2, w_byte};
  assign w_col_ok  = (w_start16 <= w_end16) && (w_end16 < LP_COLS);
  assign w_row_ok  = (w_start16 <= w_end16) && (w_end16 < LP_ROWS);

  // ------------------------------------------------------------ datapath
  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      o_cmd_valid   <= 1'b0;
      o_cmd         <= '0;
      o_param_valid <= 1'b0;
      o_param       <= '0;
      o_pixel_valid <= 1'b0;
      o_pixel_data  <= '0;
      o_pixel_x     <= '0;
      o_pixel_y     <= '0;
      o_frame_done  <= 1'b0;
      r_mode        <= PM_GENERIC;
      r_idx         <= '0;
      r_pbuf0       <= '0;
      r_pbuf1       <= '0;
      r_pbuf2       <= '0;
      r_col_start   <= '0;
      r_col_end     <= LP_COL_LAST;
      r_row_start   <= '0;
      r_row_end     <= LP_ROW_LAST;
      r_x           <= '0;
      r_y           <= '0;
      r_pix_first   <= '0;
`ifdef LCD_BUS_RECEIVER_MADCTL_EN
      r_mv          <= 1'b0;
`endif
    end else begin
      o_cmd_valid   <= w_cmd_evt;
      o_param_valid <= w_param_evt;
      o_pixel_valid <= w_pix_done;
      o_frame_done  <= w_pix_done & w_wrap;

      if (w_cmd_evt) begin
        o_cmd <= w_byte;
        r_idx <= '0;
        case (w_byte)
          CMD_CASET:  r_mode <= PM_CASET;
          CMD_PASET:  r_mode <= PM_PASET;
`ifdef LCD_BUS_RECEIVER_MADCTL_EN
          CMD_MADCTL: r_mode <= PM_MADCTL;
`endif
          default:    r_mode <= PM_GENERIC;
        endcase
        if (w_byte == CMD_RAMWR) begin
          r_x <= r_col_start;
          r_y <= r_row_start;
        end
      end

      if (w_param_evt) begin
        o_param <= w_byte;
        if (r_idx != 3'd4) r_idx <= r_idx + 3'd1;
        case (r_idx)
          3'd0:    r_pbuf0 <= w_byte;
          3'd1:    r_pbuf1 <= w_byte;
          3'd2:    r_pbuf2 <= w_byte;
          default: ;
        endcase
        if (r_idx == 3'd3) begin
          if (r_mode == PM_CASET && w_col_ok) begin
            r_col_start <= w_start16[8:0];
            r_col_end   <= w_end16[8:0];
          end
          if (r_mode == PM_PASET && w_row_ok) begin
            r_row_start <= w_start16[8:0];
            r_row_end   <= w_end16[8:0];
          end
        end
`ifdef LCD_BUS_RECEIVER_MADCTL_EN
        if (r_mode == PM_MADCTL && r_idx == 3'd0) r_mv <= w_byte[MADCTL_MV];
`endif
      end

      if (w_pix_lat) r_pix_first <= w_byte;

      if (w_pix_done) begin
        o_pixel_data <= pixel_word(r_pix_first, w_byte, LP_LOW_FIRST);
        o_pixel_x    <= r_x;
        o_pixel_y    <= r_y;
        r_x          <= w_x_adv;
        r_y          <= w_y_adv;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
module tb_lcd_bus_receiver;

  localparam int COLS = 240;
  localparam int ROWS = 320;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_wr, lcd_cs, lcd_rst;
  logic        o_cmd_valid, o_param_valid, o_pixel_valid, o_frame_done;
  logic [7:0]  o_cmd, o_param;
  logic [15:0] o_pixel_data;
  logic [8:0]  o_pixel_x, o_pixel_y;

  lcd_bus_receiver #(.P_COLS(COLS), .P_ROWS(ROWS), .P_LOW_BYTE_FIRST(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_lcd_data(lcd_data), .i_lcd_rs(lcd_rs),
    .i_lcd_wr(lcd_wr), .i_lcd_cs_inverted(lcd_cs), .i_lcd_reset_inverted(lcd_rst),
    .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_param_valid(o_param_valid),
    .o_param(o_param), .o_pixel_valid(o_pixel_valid), .o_pixel_data(o_pixel_data),
    .o_pixel_x(o_pixel_x), .o_pixel_y(o_pixel_y), .o_frame_done(o_frame_done));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // pixel record: {frame_done, y[8:0], x[8:0], data[15:0]}
  logic [7:0]  obs_cmd[$], obs_param[$], exp_cmd[$], exp_param[$];
  logic [34:0] obs_pix[$], exp_pix[$];
  int          multi_pulse = 0;
  int          stray_frame = 0;
  int          mon_n;

  always @(negedge clk) begin
    mon_n = int'(o_cmd_valid) + int'(o_param_valid) + int'(o_pixel_valid);
    if (mon_n > 1) multi_pulse++;
    if (o_frame_done && !o_pixel_valid) stray_frame++;
    if (o_cmd_valid)   obs_cmd.push_back(o_cmd);
    if (o_param_valid) obs_param.push_back(o_param);
    if (o_pixel_valid) obs_pix.push_back({o_frame_done, o_pixel_y, o_pixel_x, o_pixel_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model (window + linear index)
  int         m_cs, m_ce, m_rs, m_re, m_k, m_mode, m_idx, m_pb[4];
  bit         m_mv, m_half, ptr_ok;
  logic [7:0] m_cmd, m_first;

  task automatic model_reset();
    m_cs = 0; m_ce = COLS - 1; m_rs = 0; m_re = ROWS - 1;
    m_k = 0; m_mv = 0; m_mode = 0; m_half = 0; m_idx = 0; ptr_ok = 1;
  endtask

  task automatic model_byte(input logic rs, input logic [7:0] b);
    int w, h, x, y, s, e;
    if (!rs) begin
      exp_cmd.push_back(b);
      m_cmd = b; m_idx = 0; m_half = 0;
      if (b == 8'h2C) begin m_k = 0; m_mode = 2; ptr_ok = 1; end
      else if (b == 8'h3C) m_mode = 2;
      else m_mode = 1;
      if (b == 8'h2A || b == 8'h2B || b == 8'h36) ptr_ok = 0;
    end else if (m_mode == 1) begin
      exp_param.push_back(b);
      if (m_idx < 4) m_pb[m_idx] = int'(b);
      m_idx++;
      if (m_idx == 4) begin
        s = m_pb[0] * 256 + m_pb[1];
        e = m_pb[2] * 256 + m_pb[3];
        if (m_cmd == 8'h2A && s <= e && e < COLS) begin m_cs = s; m_ce = e; end
        if (m_cmd == 8'h2B && s <= e && e < ROWS) begin m_rs = s; m_re = e; end
      end
`ifdef LCD_BUS_RECEIVER_MADCTL_EN
      if (m_cmd == 8'h36 && m_idx == 1) m_mv = b[5];
`endif
    end else if (m_mode == 2) begin
      if (!m_half) begin
        m_first = b; m_half = 1;
      end else begin
        m_half = 0;
        w = m_ce - m_cs + 1; h = m_re - m_rs + 1;
        if (!m_mv) begin x = m_cs + m_k % w; y = m_rs + m_k / w; end
        else       begin y = m_rs + m_k % h; x = m_cs + m_k / h; end
        exp_pix.push_back({(m_k == w * h - 1), 9'(y), 9'(x), b, m_first});
        m_k = (m_k + 1) % (w * h);
      end
    end
  endtask

  // ---------------- bus drivers
  task automatic bus_write(input logic rs, input logic [7:0] b);
    model_byte(rs, b);
    @(negedge clk); lcd_data = b; lcd_rs = rs; lcd_wr = 1'b0;
    repeat (3) @(negedge clk); lcd_wr = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic deselect();
    @(negedge clk); lcd_cs = 1'b0;
    repeat (4) @(negedge clk); lcd_cs = 1'b1;
    repeat (4) @(negedge clk);
    m_mode = 0; m_half = 0;
  endtask

  task automatic send_window(input logic [7:0] cmd, input int s, input int e);
    logic [15:0] s16, e16;
    s16 = 16'(s); e16 = 16'(e);
    bus_write(0, cmd);
    bus_write(1, s16[15:8]); bus_write(1, s16[7:0]);
    bus_write(1, e16[15:8]); bus_write(1, e16[7:0]);
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      bus_write(1, 8'($urandom)); bus_write(1, 8'($urandom));
    end
  endtask

  task automatic compare_all(input string tag);
    repeat (4) @(negedge clk); #1;
    check($sformatf("%s_ncmd", tag), 64'(obs_cmd.size()), 64'(exp_cmd.size()));
    check($sformatf("%s_nparam", tag), 64'(obs_param.size()), 64'(exp_param.size()));
    check($sformatf("%s_npix", tag), 64'(obs_pix.size()), 64'(exp_pix.size()));
    for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), 64'(obs_cmd[i]), 64'(exp_cmd[i]));
    for (int i = 0; i < exp_param.size() && i < obs_param.size(); i++)
      check($sformatf("%s_param%0d", tag, i), 64'(obs_param[i]), 64'(exp_param[i]));
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++)
      check($sformatf("%s_pix%0d", tag, i), 64'(obs_pix[i]), 64'(exp_pix[i]));
    obs_cmd.delete(); obs_param.delete(); obs_pix.delete();
    exp_cmd.delete(); exp_param.delete(); exp_pix.delete();
  endtask

  int t2x[5] = '{10, 11, 10, 11, 10};
  int t2y[5] = '{5, 5, 6, 6, 5};
  int t2f[5] = '{0, 0, 0, 1, 0};
  int t6x[4], t6y[4];
  logic [34:0] pr;

  initial begin
    rst = 1'b1; lcd_data = '0; lcd_rs = 1'b0; lcd_wr = 1'b1; lcd_cs = 1'b0; lcd_rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_valid", 64'(o_cmd_valid), 0);
    check("rst_param_valid", 64'(o_param_valid), 0);
    check("rst_pixel_valid", 64'(o_pixel_valid), 0);
    check("rst_frame_done", 64'(o_frame_done), 0);
    check("rst_cmd", 64'(o_cmd), 0);
    check("rst_param", 64'(o_param), 0);
    check("rst_pixel_data", 64'(o_pixel_data), 0);
    lcd_cs = 1'b1;
    repeat (4) @(negedge clk);

    // 1: first pixel and its latency
    bus_write(0, 8'h2C);
    bus_write(1, 8'h34);
    model_byte(1, 8'h12);
    @(negedge clk); lcd_data = 8'h12; lcd_rs = 1'b1; lcd_wr = 1'b0;
    repeat (3) @(negedge clk); lcd_wr = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_early", 64'(o_pixel_valid), 0);
    @(negedge clk);
    check("lat_valid", 64'(o_pixel_valid), 1);
    check("lat_data", 64'(o_pixel_data), 64'h1234);
    check("lat_x", 64'(o_pixel_x), 0);
    check("lat_y", 64'(o_pixel_y), 0);
    compare_all("t1");

    // 2: 2x2 window traversal and wrap
    send_window(8'h2A, 10, 11);
    send_window(8'h2B, 5, 6);
    bus_write(0, 8'h2C);
    send_pixels(5);
    repeat (4) @(negedge clk); #1;
    for (int i = 0; i < 5 && i < obs_pix.size(); i++) begin
      pr = obs_pix[i];
      check($sformatf("t2_x%0d", i), 64'(pr[24:16]), 64'(t2x[i]));
      check($sformatf("t2_y%0d", i), 64'(pr[33:25]), 64'(t2y[i]));
      check($sformatf("t2_fd%0d", i), 64'(pr[34]), 64'(t2f[i]));
    end
    compare_all("t2");

    // 3: start > end leaves window alone
    send_window(8'h2A, 32, 16);
    bus_write(0, 8'h2C);
    send_pixels(1);
    repeat (4) @(negedge clk); #1;
    check("t3_x", 64'(o_pixel_x), 10);
    compare_all("t3");

    // 4: deselect discards half pixel
    bus_write(0, 8'h2C);
    bus_write(1, 8'h34);
    deselect();
    bus_write(0, 8'h3C);
    bus_write(1, 8'h78);
    bus_write(1, 8'h56);
    repeat (4) @(negedge clk); #1;
    check("t4_data", 64'(o_pixel_data), 64'h5678);
    compare_all("t4");

    // 5: generic command with parameter
    bus_write(0, 8'h11);
    bus_write(1, 8'hAB);
    repeat (4) @(negedge clk); #1;
    check("t5_cmd", 64'(o_cmd), 64'h11);
    compare_all("t5");

    // 6: MADCTL traversal order
`ifdef LCD_BUS_RECEIVER_MADCTL_EN
    t6x = '{0, 0, 1, 1}; t6y = '{0, 1, 0, 1};
`else
    t6x = '{0, 1, 0, 1}; t6y = '{0, 0, 1, 1};
`endif
    bus_write(0, 8'h36); bus_write(1, 8'h20);
    send_window(8'h2A, 0, 1);
    send_window(8'h2B, 0, 1);
    bus_write(0, 8'h2C);
    send_pixels(4);
    repeat (4) @(negedge clk); #1;
    for (int i = 0; i < 4 && i < obs_pix.size(); i++) begin
      pr = obs_pix[i];
      check($sformatf("t6_x%0d", i), 64'(pr[24:16]), 64'(t6x[i]));
      check($sformatf("t6_y%0d", i), 64'(pr[33:25]), 64'(t6y[i]));
    end
    compare_all("t6");

    // 7: bus reset restores defaults
    @(negedge clk); lcd_rst = 1'b1;
    repeat (4) @(negedge clk); lcd_rst = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
    check("t7_cmd", 64'(o_cmd), 0);
    bus_write(0, 8'h3C);
    send_pixels(2);
    compare_all("t7");

    // 8: randomized transactions against the model
    for (int t = 0; t < 160; t++) begin
      int kind, s, e, n;
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1: begin
          if (kind == 0) s = $urandom_range(0, COLS - 1);
          else           s = $urandom_range(0, ROWS - 1);
          e = s + $urandom_range(0, 3);
          if ($urandom_range(0, 4) == 0) e = $urandom_range(0, 65535);
          send_window(kind == 0 ? 8'h2A : 8'h2B, s, e);
          if ($urandom_range(0, 3) == 0) bus_write(1, 8'($urandom));
        end
        2, 3: begin
          bus_write(0, (kind == 3 && ptr_ok) ? 8'h3C : 8'h2C);
          n = $urandom_range(0, 8);
          send_pixels(n);
          if ($urandom_range(0, 3) == 0) bus_write(1, 8'($urandom));
        end
        4: begin
          logic [7:0] c;
          c = 8'($urandom);
          if (c == 8'h2A || c == 8'h2B || c == 8'h2C || c == 8'h3C || c == 8'h36) c = 8'h00;
          bus_write(0, c);
          n = $urandom_range(0, 5);
          for (int i = 0; i < n; i++) bus_write(1, 8'($urandom));
        end
        5: begin
          bus_write(0, 8'h2C);
          bus_write(1, 8'($urandom));
          deselect();
        end
        6: begin
          bus_write(0, 8'h36);
          bus_write(1, $urandom_range(0, 1) ? 8'h20 : 8'h00);
        end
        default: begin
          deselect();
          bus_write(1, 8'($urandom));
        end
      endcase
      if (t % 10 == 9) compare_all($sformatf("rnd%0d", t));
    end
    compare_all("rnd_end");

    check("one_pulse_per_cycle", 64'(multi_pulse), 0);
    check("frame_done_alone", 64'(stray_frame), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
